// File: rtl/dscnn_l3_pkg.sv
// Shared constants for the DSCNN layer-3 datapath: activation/accumulator widths,
// the requantization pair (M0, n) and the matching dequantization coefficient.
package dscnn_l3_pkg;

   localparam int L3_ACT_W    = 8;
   localparam int L3_ACC_W    = 22;
   localparam int L3_M0       = 69;
   localparam int L3_N        = 13;
   localparam int L3_DQ_K     = 7598;
   localparam int L3_DQ_K_W   = 16;
   localparam int L3_DQ_FRAC  = 6;
   localparam int L3_CH_NUM   = 16;

   // Nominal inverse of the rescale, 2^(n+frac)/M0 rounded; used when regenerating tables.
   function automatic int l3_dq_k_nominal();
      return ((2 ** (L3_N + L3_DQ_FRAC)) + (L3_M0 / 2)) / L3_M0;
   endfunction

endpackage

// File: rtl/dequant_3_mul.sv
// Registered signed multiplier (INPUT_W x BW) with clock enable, kept separate so the
// product maps cleanly onto a single DSP slice.
module dequant_3_mul #(
   parameter int AW = 8,
   parameter int BW = 17,
   localparam int PW = AW + BW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic signed [AW-1:0] a_i,
   input  logic signed [BW-1:0] b_i,
   output logic signed [PW-1:0] p_o
);

   logic signed [PW-1:0] p_q;
   logic signed [PW-1:0] p_d;

   always_comb begin
      p_d = p_q;
      if (en) begin
         p_d = PW'(a_i) * PW'(b_i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign p_o = p_q;

endmodule

// File: rtl/dequant_3.sv
// Streaming layer-3 dequantizer: per-channel scale table, 3-stage valid/ready pipeline.
// Build option DEQUANT_3_SAT_EN: clamp the rounded result instead of wrapping it.
import dscnn_l3_pkg::*;

module dequant_3 #(
   parameter int INPUT_W   = L3_ACT_W,
   parameter int OUTPUT_W  = L3_ACC_W,
   parameter int K_W       = L3_DQ_K_W,
   parameter int FRAC      = L3_DQ_FRAC,
   parameter int CH_NUM    = L3_CH_NUM,
   parameter int DEFAULT_K = L3_DQ_K,
   localparam int AW       = $clog2(CH_NUM)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [INPUT_W-1:0]  data_i,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUTPUT_W-1:0] data_o,
   output logic                out_last,
   input  logic                cfg_we,
   input  logic [AW-1:0]       cfg_addr,
   input  logic [K_W-1:0]      cfg_data
);

   localparam int PW = INPUT_W + K_W + 1;
   localparam int RW = (PW + 1 > OUTPUT_W + 1) ? PW + 1 : OUTPUT_W + 1;
   localparam logic signed [RW-1:0] RND     = RW'(2 ** (FRAC - 1));
   localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (OUTPUT_W - 1)) - 1);
   localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

   logic en;
   logic accept;
   logic ch_at_end;

   logic [AW-1:0] ch_q, ch_d;
   logic [K_W-1:0] k_tab_q [CH_NUM];
   logic [K_W-1:0] k_tab_d [CH_NUM];

   logic                      v1_q, v1_d;
   logic                      last1_q, last1_d;
   logic signed [INPUT_W-1:0] q1_q, q1_d;
   logic [K_W-1:0]            k1_q, k1_d;

   logic                      v2_q, v2_d;
   logic                      last2_q, last2_d;
   logic signed [PW-1:0]      p2;

   logic                      out_valid_q, out_valid_d;
   logic                      out_last_q, out_last_d;
   logic [OUTPUT_W-1:0]       data_o_q, data_o_d;

   logic signed [RW-1:0]      p_ext;
   logic signed [RW-1:0]      r_full;
   logic [OUTPUT_W-1:0]       r_sized;

   // Whole pipe advances together; in_ready is purely combinational (no skid buffer).
   assign en        = !out_valid_q || out_ready;
   assign accept    = in_valid && en;
   assign ch_at_end = (int'(ch_q) == CH_NUM - 1);

   always_comb begin
      ch_d = ch_q;
      if (accept) begin
         ch_d = ch_at_end ? '0 : ch_q + AW'(1);
      end
   end

   // Same-edge write and read: S1 captures the pre-write coefficient.
   always_comb begin
      k_tab_d = k_tab_q;
      if (cfg_we && (int'(cfg_addr) < CH_NUM)) begin
         k_tab_d[cfg_addr] = cfg_data;
      end
   end

   always_comb begin
      v1_d    = v1_q;
      q1_d    = q1_q;
      k1_d    = k1_q;
      last1_d = last1_q;
      if (en) begin
         v1_d = accept;
         if (accept) begin
            q1_d    = data_i;
            k1_d    = k_tab_q[ch_q];
            last1_d = ch_at_end;
         end
      end
   end

   dequant_3_mul #(
      .AW (INPUT_W),
      .BW (K_W + 1)
   ) u_mul (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a_i (q1_q),
      .b_i ($signed({1'b0, k1_q})),
      .p_o (p2)
   );

   always_comb begin
      v2_d    = v2_q;
      last2_d = last2_q;
      if (en) begin
         v2_d    = v1_q;
         last2_d = last1_q;
      end
   end

   // Round half up, then arithmetic shift down to the accumulator scale.
   always_comb begin
      p_ext  = RW'(p2);
      r_full = (p_ext + RND) >>> FRAC;
`ifdef DEQUANT_3_SAT_EN
      if (r_full > SAT_MAX) begin
         r_sized = OUTPUT_W'(SAT_MAX);
      end else if (r_full < SAT_MIN) begin
         r_sized = OUTPUT_W'(SAT_MIN);
      end else begin
         r_sized = OUTPUT_W'(r_full);
      end
`else
      r_sized = OUTPUT_W'(r_full);
`endif
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      data_o_d    = data_o_q;
      if (en) begin
         out_valid_d = v2_q;
         if (v2_q) begin
            data_o_d   = r_sized;
            out_last_d = last2_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_q        <= '0;
         v1_q        <= 1'b0;
         q1_q        <= '0;
         k1_q        <= '0;
         last1_q     <= 1'b0;
         v2_q        <= 1'b0;
         last2_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         data_o_q    <= '0;
         for (int i = 0; i < CH_NUM; i++) begin
            k_tab_q[i] <= K_W'(DEFAULT_K);
         end
      end else begin
         ch_q        <= ch_d;
         v1_q        <= v1_d;
         q1_q        <= q1_d;
         k1_q        <= k1_d;
         last1_q     <= last1_d;
         v2_q        <= v2_d;
         last2_q     <= last2_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         data_o_q    <= data_o_d;
         k_tab_q     <= k_tab_d;
      end
   end

   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign data_o    = data_o_q;

endmodule

// File: tb/tb_dequant_3.sv
// Directed + randomized bench for dequant_3 against an arithmetic reference model
// (round-half-up of q*K/64, per-channel table, channel wrap at 16).
module tb_dequant_3;

   localparam int CH  = 16;
   localparam int OW  = 22;
   localparam int DEF_K = 7598;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  data_i;
   logic        out_valid;
   logic        out_ready;
   logic [21:0] data_o;
   logic        out_last;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [15:0] cfg_data;

   always #5 clk = ~clk;

   dequant_3 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_i    (data_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_o    (data_o),
      .out_last  (out_last),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data)
   );

   typedef struct {
      longint data;
      logic   last;
   } exp_t;

   exp_t   exp_q[$];
   int     k_m [CH];
   int     ch_m;
   int     vectors = 0;
   int     miscompares = 0;

   function automatic longint floor_div(longint a, longint b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   // floor(q*K/64 + 1/2), then clamp or wrap into a 22-bit signed word.
   function automatic longint dq(int q, int k);
      longint r;
      longint span;
      r = floor_div(longint'(q) * longint'(k) * 2 + 64, 128);
      span = longint'(1) << OW;
`ifdef DEQUANT_3_SAT_EN
      if (r > span / 2 - 1) r = span / 2 - 1;
      if (r < -(span / 2)) r = -(span / 2);
`else
      r = r % span;
      if (r < 0) r = r + span;
      if (r >= span / 2) r = r - span;
`endif
      return r;
   endfunction

   task automatic check(string tag, longint obs, longint expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      ch_m = 0;
      for (int i = 0; i < CH; i++) k_m[i] = DEF_K;
   endtask

   // One clock: check outputs at the falling edge, update the model, step past the rising edge.
   task automatic cycle();
      @(negedge clk);
      if (!rst) begin
         check("in_ready", longint'(in_ready), longint'(!out_valid || out_ready));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               check("data_o", longint'($signed(data_o)), exp_q[0].data);
               check("out_last", longint'(out_last), longint'(exp_q[0].last));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back('{data: dq(int'($signed(data_i)), k_m[ch_m]), last: (ch_m == CH - 1)});
            ch_m = (ch_m + 1) % CH;
         end
         if (cfg_we) k_m[cfg_addr] = int'(cfg_data);
      end else begin
         model_reset();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      cfg_we = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      cfg_we = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
      check("drain_empty", exp_q.size(), 0);
      cycle();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; data_i = '0; out_ready = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      model_reset();
      do_reset();

      // Reset state
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_data_o", longint'(data_o), 0);
      check("rst_out_last", longint'(out_last), 0);
      check("rst_in_ready", longint'(in_ready), 1);

      // First transaction: q=100 on channel 0, exact latency
      out_ready = 1'b1; in_valid = 1'b1; data_i = 8'd100;
      cycle();
      in_valid = 1'b0;
      check("lat_e0", longint'(out_valid), 0);
      cycle();
      check("lat_e1", longint'(out_valid), 0);
      cycle();
      check("lat_e2_valid", longint'(out_valid), 1);
      check("lat_e2_data", longint'($signed(data_o)), 11872);
      check("lat_e2_last", longint'(out_last), 0);
      drain();

      // 16 back-to-back q=1 from channel 0
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; data_i = 8'd1;
      cycle();
      for (int i = 1; i < CH; i++) begin
         cycle();
         if (i == 2) check("b2b_first", longint'($signed(data_o)), 119);
      end
      drain();

      // Extreme negative and zero with default K
      in_valid = 1'b1; data_i = 8'h80;
      cycle();
      data_i = 8'h00;
      cycle();
      in_valid = 1'b0;
      cycle();
      check("neg128", longint'($signed(data_o)), -15196);
      cycle();
      check("zero", longint'($signed(data_o)), 0);
      drain();

      // Backpressure hold with full pipe
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_i = 8'(i * 37 - 60);
         cycle();
      end
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         data_i = 8'(i + 9);
         #1;
         check("hold_in_ready", longint'(in_ready), 0);
         check("hold_out_valid", longint'(out_valid), 1);
         cycle();
      end
      drain();

      // Table write coinciding with a channel-2 accept
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; data_i = 8'd5;
      cycle(); cycle();
      cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 16'd64;
      cycle();
      cfg_we = 1'b0;
      for (int i = 3; i < CH + 3; i++) cycle();
      drain();

      // Large coefficient on channel 0
      do_reset();
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'hFFFF;
      cycle();
      cfg_we = 1'b0; out_ready = 1'b1; in_valid = 1'b1; data_i = 8'd127;
      cycle();
      data_i = 8'h80;
      for (int i = 0; i < CH; i++) cycle();
      drain();

      // Randomized traffic with interleaved table writes
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         data_i    = 8'($urandom);
         cfg_we    = ($urandom_range(11) == 0);
         cfg_addr  = 4'($urandom);
         cfg_data  = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(9000));
         cycle();
      end
      drain();

      // Reset while the pipe is busy
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_i = 8'($urandom);
         cycle();
      end
      rst = 1'b1; out_ready = 1'b0;
      cycle();
      check("midrst_out_valid", longint'(out_valid), 0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("midrst_in_ready", longint'(in_ready), 1);
      cycle(); cycle();
      check("midrst_quiet", longint'(out_valid), 0);
      cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 16'd1;
      cycle();
      cfg_we = 1'b0; in_valid = 1'b1; out_ready = 1'b1; data_i = 8'd90;
      for (int i = 0; i < 5; i++) cycle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
